// File: rtl/alu_pkg.sv
// Shared ALU encodings and the multiplier sequencer state type.
// The CPU datapath and the multiply sequencer both import this package.
package alu_pkg;

    localparam logic [1:0] ALU_OP_ADD      = 2'b00;
    localparam logic [1:0] ALU_OP_SUB      = 2'b01;
    localparam logic [1:0] ALU_OP_AND      = 2'b10;
    localparam logic [1:0] ALU_OP_OR       = 2'b11;

    localparam logic [1:0] ALU_SHIFT_NONE  = 2'b00;
    localparam logic [1:0] ALU_SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] ALU_SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] ALU_SHIFT_ROT   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/grant bus between a client block and the shared 8-bit ALU.
// The master side is the client; the slave side is the ALU plus its arbiter.
interface alu_mul_seq_if #(
    parameter int WIDTH = 8
);
    logic             alu_req;
    logic             alu_gnt;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_sel;
    logic [1:0]       alu_shift;
    logic             alu_cout;
    logic [WIDTH-1:0] alu_result;

    modport master (
        output alu_req, alu_a, alu_b, alu_sel, alu_shift,
        input  alu_gnt, alu_cout, alu_result
    );

    modport slave (
        input  alu_req, alu_a, alu_b, alu_sel, alu_shift,
        output alu_gnt, alu_cout, alu_result
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier that borrows the shared ALU as its adder,
// one granted ALU add per multiplier bit; stalls cleanly while the CPU holds the ALU.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 zero,
    alu_mul_seq_if.master        alu
);

    mul_state_t       state, state_next;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [CNT_W-1:0] count;
    logic             last_iter;
    logic [2*WIDTH-1:0] shifted;

    assign last_iter = (count == CNT_W'(WIDTH - 1));

    // The carry lands in acc's MSB, so {acc, mq} after the shift is the full partial product.
    assign shifted = {alu.alu_cout, alu.alu_result, mq[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        busy          = 1'b0;
        done          = 1'b0;
        alu.alu_req   = 1'b0;
        alu.alu_a     = '0;
        alu.alu_b     = '0;
        alu.alu_sel   = ALU_OP_ADD;
        alu.alu_shift = ALU_SHIFT_NONE;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy        = 1'b1;
                alu.alu_req = 1'b1;
                alu.alu_a   = acc;
                alu.alu_b   = mq[0] ? mcand : '0;
                if (alu.alu_gnt && last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Without a grant nothing moves, so a stall of any length loses no partial state.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            acc     <= '0;
            mq      <= '0;
            count   <= '0;
            product <= '0;
            zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= op_a;
                        mq    <= op_b;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                RUN: begin
                    if (alu.alu_gnt) begin
                        acc   <= shifted[2*WIDTH-1:WIDTH];
                        mq    <= shifted[WIDTH-1:0];
                        count <= count + 1'b1;
                        if (last_iter) begin
                            product <= shifted;
                            zero    <= (shifted == '0);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: directed multiplies against a behavioural ALU,
// with grant stalls, ignored restarts and a mid-run reset.
module tb_alu_mul_seq;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        zero;
    logic        gnt;
    bit          check_b_zero;
    int          cyc;
    int          checks;
    int          errors;

    typedef struct {
        logic [15:0] prod;
        logic        zero;
        int          start_cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    alu_mul_seq_if #(.WIDTH(8)) bus ();

    // Behavioural stand-in for the shared ALU: a plain 9-bit add.
    assign {bus.alu_cout, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    assign bus.alu_gnt = gnt;

    alu_mul_seq #(.WIDTH(8), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .zero    (zero),
        .alu     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse, and polices the ALU bus during RUN.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_done", 32'(done), 32'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_output("product", 32'(product), 32'(e.prod));
                    check_output("zero", 32'(zero), 32'(e.zero));
                    check_output("latency", 32'(cyc - e.start_cyc + 1), 32'(e.lat));
                    check_output("busy_in_done", 32'(busy), 32'(0));
                end
            end
            if (busy) begin
                check_output("alu_req", 32'(bus.alu_req), 32'(1));
                check_output("alu_sel", 32'(bus.alu_sel), 32'(ALU_OP_ADD));
                check_output("alu_shift", 32'(bus.alu_shift), 32'(ALU_SHIFT_NONE));
                if (check_b_zero) begin
                    check_output("alu_b_zero", 32'(bus.alu_b), 32'(0));
                end
            end else begin
                check_output("alu_req_idle", 32'(bus.alu_req), 32'(0));
            end
        end
    end

    // Issue one multiply from IDLE at a negedge; returns at a negedge with the DUT back in IDLE.
    // reset_at >= 0 aborts the op with rst on that RUN cycle index (no result expected).
    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b,
                                  input logic [15:0] exp_prod, input logic [7:0] stall_mask,
                                  input int exp_lat, input bit restart_mid, input int reset_at);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        if (reset_at < 0) begin
            sb.push_back('{exp_prod, (exp_prod == 16'h0), cyc + 1, exp_lat});
        end
        @(negedge clk);
        start = 1'b0;
        op_a  = 8'hA5;
        op_b  = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            if (i == reset_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_output("rst_busy", 32'(busy), 32'(0));
                check_output("rst_done", 32'(done), 32'(0));
                check_output("rst_product", 32'(product), 32'(0));
                check_output("rst_zero", 32'(zero), 32'(0));
                return;
            end
            if (stall_mask[i]) begin
                gnt = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check_output("stall_req", 32'(bus.alu_req), 32'(1));
                    check_output("stall_busy", 32'(busy), 32'(1));
                end
                gnt = 1'b1;
            end
            if (restart_mid && i == 3) begin
                start = 1'b1;
                op_a  = 8'hFF;
                op_b  = 8'h77;
            end
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        cyc          = 0;
        checks       = 0;
        errors       = 0;
        check_b_zero = 1'b0;
        gnt          = 1'b1;
        rst          = 1'b1;
        start        = 1'b0;
        op_a         = 8'h00;
        op_b         = 8'h00;
        repeat (2) @(negedge clk);
        check_output("reset_busy", 32'(busy), 32'(0));
        check_output("reset_done", 32'(done), 32'(0));
        check_output("reset_product", 32'(product), 32'(0));
        check_output("reset_zero", 32'(zero), 32'(0));
        check_output("reset_req", 32'(bus.alu_req), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        apply_stimulus(8'h0F, 8'h11, 16'h00FF, 8'h00, 9, 1'b0, -1);
        apply_stimulus(8'hFF, 8'hFF, 16'hFE01, 8'h00, 9, 1'b0, -1);
        apply_stimulus(8'h80, 8'h02, 16'h0100, 8'h00, 9, 1'b0, -1);

        check_b_zero = 1'b1;
        apply_stimulus(8'h00, 8'h5A, 16'h0000, 8'h00, 9, 1'b0, -1);
        check_b_zero = 1'b0;

        apply_stimulus(8'h0F, 8'h11, 16'h00FF, 8'b0010_0100, 15, 1'b0, -1);
        apply_stimulus(8'h12, 8'h34, 16'h03A8, 8'h00, 9, 1'b1, -1);
        apply_stimulus(8'h07, 8'h09, 16'h003F, 8'h00, 9, 1'b0, 3);
        @(negedge clk);
        apply_stimulus(8'h03, 8'h05, 16'h000F, 8'h00, 9, 1'b0, -1);

        repeat (4) @(negedge clk);
        check_output("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle unsigned multiplier sequencer for the 8-bit CPU.
- Uses the shared 8-bit ALU as its adder, in shift-and-add form, one ALU add per multiplier bit.
- Requests the ALU through a req/gnt pair, so the CPU datapath keeps priority.
- Delivers a 2*WIDTH product with a one-cycle done pulse and a zero flag.

Parameters:
- WIDTH, 8: operand width; must equal the ALU data width.
- CNT_W, 4: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a multiply; sampled only in IDLE.
- op_a  in  WIDTH  multiplicand; latched when start is accepted.
- op_b  in  WIDTH  multiplier; latched when start is accepted.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.
- product  out  2*WIDTH  registered result; held until the next accepted start.
- zero  out  1  registered; high iff product == 0.
- alu_req  out  1  high in RUN.
- alu_gnt  in  1  ALU granted to this block this cycle.
- alu_a  out  WIDTH  ALU operand a.
- alu_b  out  WIDTH  ALU operand b.
- alu_sel  out  2  ALU operation select; always ALU_OP_ADD.
- alu_shift  out  2  ALU shift control; always ALU_SHIFT_NONE.
- alu_cout  in  1  ALU carry out.
- alu_result  in  WIDTH  ALU result.

Behaviour:
- Reset (rst=1 at an edge): state to IDLE.
  - busy, done, alu_req, zero, product, internal acc/mq/mcand/count all clear to 0.
  - Reset applies in any state and aborts an in-flight multiply; no done is produced.
- Internal registers:
  - mcand[WIDTH]: latched multiplicand.
  - acc[WIDTH]: high half of the partial product.
  - mq[WIDTH]: multiplier / low half.
  - count[CNT_W]: iteration counter.
- IDLE:
  - busy=0, alu_req=0.
  - alu_a/alu_b driven 0; alu_sel=ALU_OP_ADD; alu_shift=ALU_SHIFT_NONE.
  - If start=1: mcand<=op_a, mq<=op_b, acc<=0, count<=0, go to RUN. product and zero are unchanged.
- RUN:
  - busy=1, alu_req=1, alu_a=acc.
  - alu_b = mq[0] ? mcand : 0.
  - If alu_gnt=1 at an edge:
    - acc <= {alu_cout, alu_result[WIDTH-1:1]}.
    - mq <= {alu_result[0], mq[WIDTH-1:1]}.
    - count <= count+1.
  - If alu_gnt=0: all registers hold; no partial state is lost. Stalls may be any length and may occur on any iteration.
  - On the granted edge with count==WIDTH-1:
    - product <= post-shift {acc, mq}.
    - zero <= (that value == 0).
    - Go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, alu_req=0; then unconditionally go to IDLE.
  - start during DONE is ignored.
  - start is accepted on the next cycle (IDLE), giving back-to-back throughput of 1 + WIDTH + 1 cycles.
- start while RUN or DONE: ignored; op_a/op_b are not re-sampled.
- Latency with continuous grant: start sampled at edge E0, WIDTH granted edges E1..E8 (WIDTH=8), done high during the cycle after E8, product valid from E8 onward.
- Arithmetic: unsigned only. The carry from each add enters acc's MSB, so the full 2*WIDTH product never overflows. alu_cout is meaningful only in RUN with grant.

Decomposition:
- Shared package alu_pkg:
  - ALU_OP_ADD=2'b00, ALU_SHIFT_NONE=2'b00; the other ALU_sel/load_shift encodings also live here.
  - The state enum {IDLE, RUN, DONE}.
- No sub-module. The ALU is external and shared; a grant arbiter is outside this block.

Test Plan:
- op_a=0x0F, op_b=0x11, start 1 cycle, gnt tied 1 -> done pulse exactly 9 cycles after the start edge, product=0x00FF, zero=0; alu_sel=00 throughout RUN.
- op_a=0xFF, op_b=0xFF -> product=0xFE01 (exercises alu_cout into acc MSB); then op_a=0x80, op_b=0x02 back-to-back start in the cycle after done -> product=0x0100.
- op_a=0x00, op_b=0x5A -> product=0x0000, zero=1; alu_b=0 on every RUN cycle.
- op_a=0x0F, op_b=0x11 with alu_gnt low on iterations 2 and 5 for 3 cycles each -> alu_req stays 1 during stalls, done 15 cycles after start, product=0x00FF.
- Start accepted with 0x12*0x34, start re-pulsed with new operands mid-RUN -> ignored, product=0x03A8.
- rst asserted on the 4th RUN cycle -> next cycle busy=0, product=0, zero=0, no done pulse; a following 0x03*0x05 multiply gives 0x000F.
